// File: rtl/freq_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// freq_sweep_ctrl
//   Frequency-sweep sequencer that feeds a DDS phase accumulator. A run is
//   started with a one-cycle start pulse. The configuration is captured at
//   start and used for the whole run. Three run types exist:
//     - fixed : the start word is held until abort.
//     - linear: the word advances by f_step.
//     - log   : the word is multiplied by 10.
//   In linear and log runs, each word is held for dwell+1 cycles. A step that
//   passes f_stop, or that carries out of FW bits, either restarts the sweep
//   at f_start (repeat_en=1) or ends the run with a done pulse (repeat_en=0).
//
//   Build option:
//     FREQ_SWEEP_LOG_EN  defined   -> mode 10 runs the x10 log sweep.
//                        undefined -> no log datapath; mode 10 acts as mode 01.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   one-cycle request to begin a run (ignored while busy)
//   abort      in   end the current run; freq_word keeps its value
//   mode[1:0]  in   00 fixed, 01 linear, 10 log, 11 fixed
//   repeat_en  in   1 = restart at f_start when the sweep ends, 0 = one-shot
//                   (carries the "repeat" function; "repeat" is a reserved word)
//   f_start    in   first frequency word
//   f_stop     in   inclusive upper bound of the sweep
//   f_step     in   linear increment
//   dwell      in   each word is held dwell+1 cycles
//   freq_word  out  registered frequency word
//   freq_valid out  one-cycle pulse on every freq_word update
//   busy       out  high while a run is active
//   done       out  one-cycle pulse when a one-shot sweep ends
// -----------------------------------------------------------------------------
module freq_sweep_ctrl #(
    parameter int            FW       = 64,
    parameter int            DW       = 32,
    parameter logic [FW-1:0] RST_FREQ = FW'(64'd153722867281)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    mode,
    input  logic          repeat_en,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    output logic [FW-1:0] freq_word,
    output logic          freq_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, HOLD, DWELL, STEP} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] cnt;
    logic [FW-1:0] start_l, stop_l, step_l;
    logic [DW-1:0] dwell_l;
    logic          rpt_l;

    logic          cfg_ld, word_ld, done_set, cnt_ld;
    logic [FW-1:0] word_nxt;
    logic [DW-1:0] cnt_val;
    logic          sweep_req;

    // next-word datapath
    logic [FW:0]   nxt_lin;
    logic [FW-1:0] nxt_word;
    logic          in_range;

`ifdef FREQ_SWEEP_LOG_EN
    logic          log_l;
    logic [FW+3:0] nxt_log;

    // x10 as (x<<3)+(x<<1); four guard bits catch any overflow past FW
    assign nxt_log = ({4'b0, freq_word} << 3) + ({4'b0, freq_word} << 1);
`endif

    always_comb begin
        nxt_lin  = {1'b0, freq_word} + {1'b0, step_l};
        nxt_word = nxt_lin[FW-1:0];
        in_range = !nxt_lin[FW] && (nxt_lin[FW-1:0] <= stop_l);
`ifdef FREQ_SWEEP_LOG_EN
        if (log_l) begin
            nxt_word = nxt_log[FW-1:0];
            in_range = (nxt_log[FW+3:FW] == 4'd0) && (nxt_log[FW-1:0] <= stop_l);
        end
`endif
    end

    assign sweep_req = (mode == 2'b01) || (mode == 2'b10);
    assign busy      = (state != IDLE);

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state and control. The word held in DWELL also stays on the
    // output during STEP, so DWELL lasts only `dwell` cycles. A dwell of 0
    // skips DWELL and steps on every cycle.
    always_comb begin
        state_nxt = state;
        cfg_ld    = 1'b0;
        word_ld   = 1'b0;
        word_nxt  = freq_word;
        done_set  = 1'b0;
        cnt_ld    = 1'b0;
        cnt_val   = dwell_l;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_ld   = 1'b1;
                        word_ld  = 1'b1;
                        word_nxt = f_start;
                        if (!sweep_req) begin
                            state_nxt = HOLD;
                        end else if (dwell == '0) begin
                            state_nxt = STEP;
                        end else begin
                            state_nxt = DWELL;
                            cnt_ld    = 1'b1;
                            cnt_val   = dwell;
                        end
                    end
                end
                HOLD: state_nxt = HOLD;
                DWELL: begin
                    if (cnt <= DW'(1)) state_nxt = STEP;
                end
                STEP: begin
                    if (in_range || rpt_l) begin
                        word_ld  = 1'b1;
                        word_nxt = in_range ? nxt_word : start_l;
                        if (dwell_l == '0) begin
                            state_nxt = STEP;
                        end else begin
                            state_nxt = DWELL;
                            cnt_ld    = 1'b1;
                        end
                    end else begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // output / configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_word  <= RST_FREQ;
            freq_valid <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            start_l    <= '0;
            stop_l     <= '0;
            step_l     <= '0;
            dwell_l    <= '0;
            rpt_l      <= 1'b0;
`ifdef FREQ_SWEEP_LOG_EN
            log_l      <= 1'b0;
`endif
        end else begin
            freq_valid <= word_ld;
            done       <= done_set;
            if (word_ld) freq_word <= word_nxt;
            if (cnt_ld)              cnt <= cnt_val;
            else if (state == DWELL) cnt <= cnt - DW'(1);
            if (cfg_ld) begin
                start_l <= f_start;
                stop_l  <= f_stop;
                step_l  <= f_step;
                dwell_l <= dwell;
                rpt_l   <= repeat_en;
`ifdef FREQ_SWEEP_LOG_EN
                log_l   <= (mode == 2'b10);
`endif
            end
        end
    end

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
module tb_freq_sweep_ctrl;
    localparam int          FW      = 64;
    localparam int          DW      = 32;
    localparam logic [63:0] RST_VAL = 64'd153722867281;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, repeat_en = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [FW-1:0] f_start = '0, f_stop = '0, f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [FW-1:0] freq_word;
    logic          freq_valid, busy, done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [63:0] vq[$];

    always #5 clk = ~clk;

    freq_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .repeat_en(repeat_en), .f_start(f_start), .f_stop(f_stop),
        .f_step(f_step), .dwell(dwell), .freq_word(freq_word),
        .freq_valid(freq_valid), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: tracks the word on the output and how many more
    // cycles it must stay there; next words use wide arithmetic.
    logic [63:0]     m_word, m_start, m_stop, m_step;
    logic [67:0]     nx;
    bit              m_valid, m_busy, m_done, m_sweep, m_rpt, m_log;
    longint unsigned m_dw, m_left;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_word = RST_VAL; m_valid = 0; m_busy = 0; m_done = 0;
        end else begin
            m_valid = 0; m_done = 0;
            if (!m_busy) begin
                if (start && !abort) begin
                    m_start = f_start; m_stop = f_stop; m_step = f_step;
                    m_dw = longint'(dwell); m_rpt = repeat_en;
                    m_sweep = (mode == 2'b01) || (mode == 2'b10);
`ifdef FREQ_SWEEP_LOG_EN
                    m_log = (mode == 2'b10);
`else
                    m_log = 0;
`endif
                    m_word = f_start; m_valid = 1; m_busy = 1; m_left = m_dw + 1;
                end
            end else if (abort) begin
                m_busy = 0;
            end else if (m_sweep) begin
                m_left--;
                if (m_left == 0) begin
                    nx = m_log ? ({4'b0, m_word} * 68'd10) : ({4'b0, m_word} + {4'b0, m_step});
                    if (nx <= {4'b0, m_stop}) begin
                        m_word = nx[63:0]; m_valid = 1; m_left = m_dw + 1;
                    end else if (m_rpt) begin
                        m_word = m_start; m_valid = 1; m_left = m_dw + 1;
                    end else begin
                        m_done = 1; m_busy = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_word", freq_word, m_word);
        chk("cyc_valid", 64'(freq_valid), 64'(m_valid));
        chk("cyc_busy", 64'(busy), 64'(m_busy));
        chk("cyc_done", 64'(done), 64'(m_done));
    end

    always @(negedge clk) begin
        if (freq_valid === 1'b1) vq.push_back(freq_word);
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [63:0] qv(input int i);
        return (i < vq.size()) ? vq[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    task automatic run_start(input logic [1:0] md, input logic rp, input logic [63:0] fs,
                             input logic [63:0] fe, input logic [63:0] fp, input logic [31:0] dw);
        vq.delete(); done_cnt = 0;
        mode = md; repeat_en = rp; f_start = fs; f_stop = fe; f_step = fp; dwell = dw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string name);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s actual=no_done required=done_pulse", name);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_word", freq_word, RST_VAL);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_word", freq_word, 64'd153722867281);
        chk("idle_busy", 64'(busy), 0);
        chk("idle_valid", 64'(freq_valid), 0);

        // linear one-shot
        run_start(2'b01, 1'b0, 100, 200, 50, 2);
        wait_done(40, "lin_done");
        chk("lin_nwords", 64'(vq.size()), 3);
        chk("lin_w0", qv(0), 100);
        chk("lin_w1", qv(1), 150);
        chk("lin_w2", qv(2), 200);
        chk("lin_final", freq_word, 200);
        chk("lin_done_cnt", 64'(done_cnt), 1);

        // linear repeat; inputs scrambled mid-run must be ignored
        run_start(2'b01, 1'b1, 100, 200, 50, 2);
        @(negedge clk);
        f_step = 7; f_stop = 5; f_start = 3; mode = 2'b00; repeat_en = 1'b0; dwell = 0;
        repeat (13) @(negedge clk);
        chk("rep_w0", qv(0), 100);
        chk("rep_w1", qv(1), 150);
        chk("rep_w2", qv(2), 200);
        chk("rep_w3", qv(3), 100);
        chk("rep_w4", qv(4), 150);
        chk("rep_no_done", 64'(done_cnt), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("rep_abort_busy", 64'(busy), 0);
        chk("rep_abort_word", freq_word, 150);
        @(negedge clk);
        chk("rep_abort_done", 64'(done_cnt), 0);

        // mode 10: log sweep, or linear when the log datapath is absent
        run_start(2'b10, 1'b0, 1, 1000, 333, 0);
        wait_done(40, "log_done");
        chk("log_nwords", 64'(vq.size()), 4);
`ifdef FREQ_SWEEP_LOG_EN
        chk("log_w1", qv(1), 10);
        chk("log_w2", qv(2), 100);
`else
        chk("log_w1", qv(1), 334);
        chk("log_w2", qv(2), 667);
`endif
        chk("log_w3", qv(3), 1000);
        chk("log_final", freq_word, 1000);

        // carry out of FW bits
        run_start(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF6, 64'hFFFF_FFFF_FFFF_FFFF, 20, 1);
        wait_done(20, "carry_done");
        chk("carry_word", freq_word, 64'hFFFF_FFFF_FFFF_FFF6);
        chk("carry_nwords", 64'(vq.size()), 1);

        // fixed mode, second start ignored, abort+start in IDLE
        run_start(2'b00, 1'b0, 64'd153722867280913000, 0, 0, 0);
        repeat (3) @(negedge clk);
        mode = 2'b01; f_start = 5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("fix_word", freq_word, 64'd153722867280913000);
        chk("fix_busy", 64'(busy), 1);
        chk("fix_nwords", 64'(vq.size()), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("fix_abort_busy", 64'(busy), 0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("sa_busy", 64'(busy), 0);
        chk("sa_word", freq_word, 64'd153722867280913000);
        chk("sa_nwords", 64'(vq.size()), 1);

        // f_start above f_stop: one dwell period then one-shot end
        run_start(2'b01, 1'b0, 500, 100, 10, 1);
        wait_done(10, "inv_done");
        chk("inv_word", freq_word, 500);
        chk("inv_nwords", 64'(vq.size()), 1);

        // zero step runs until abort
        run_start(2'b01, 1'b0, 40, 100, 0, 0);
        repeat (10) @(negedge clk);
        chk("zs_busy", 64'(busy), 1);
        chk("zs_word", freq_word, 40);
        chk("zs_done", 64'(done_cnt), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // asynchronous reset mid-sweep
        run_start(2'b01, 1'b1, 100, 200, 50, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_word", freq_word, RST_VAL);
        chk("arst_busy", 64'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_word", freq_word, RST_VAL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 Parameter FW, default 64, frequency (phase-increment) word width in bits.
REQ-002 Parameter DW, default 32, dwell counter width in bits.
REQ-003 Parameter RST_FREQ, default 153722867281, freq_word value after reset (1 Hz at 120 MHz, FW=64).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a run.
REQ-007 abort  input  1  terminate the current run.
REQ-008 mode  input  2  00 fixed, 01 linear sweep, 10 log sweep, 11 treated as 00.
REQ-009 repeat  input  1  1 = restart at f_start on end of sweep; 0 = one-shot.
REQ-010 f_start  input  FW  first frequency word.
REQ-011 f_stop  input  FW  upper bound; inclusive.
REQ-012 f_step  input  FW  linear increment.
REQ-013 dwell  input  DW  each frequency held dwell+1 cycles.
REQ-014 freq_word  output  FW  registered frequency word to the DDS accumulator.
REQ-015 freq_valid  output  1  one-cycle pulse on every freq_word update.
REQ-016 busy  output  1  high in HOLD, SWEEP or DWELL.
REQ-017 done  output  1  one-cycle pulse when a one-shot sweep ends.

Function
REQ-018 States IDLE, HOLD, DWELL, STEP; IDLE after reset.
REQ-019 IDLE + start: latch mode, repeat, f_start, f_stop, f_step and dwell; freq_word <= f_start; freq_valid=1 on the next cycle; go to HOLD (mode 00/11) or DWELL (01/10).
REQ-020 Latched configuration is used for the whole run; input changes while busy have no effect.
REQ-021 start while busy is ignored.
REQ-022 HOLD: freq_word constant; exit only on abort.
REQ-023 DWELL: counter loads the latched dwell on entry, decrements each cycle, goes to STEP when it reaches 0, so each word is held exactly dwell+1 cycles.
REQ-024 STEP (one cycle) computes nxt: linear = cur + f_step in FW+1 bits; log = (cur<<3)+(cur<<1) in FW+4 bits.
REQ-025 STEP, in range (nxt <= f_stop and no carry beyond FW bits): freq_word <= nxt[FW-1:0]; freq_valid pulses; return to DWELL.
REQ-026 STEP, out of range, repeat=1: freq_word <= f_start; freq_valid pulses; return to DWELL.
REQ-027 STEP, out of range, repeat=0: freq_word holds its last in-range value; done pulses; go to IDLE.
REQ-028 f_start > f_stop: f_start is output for one dwell period, then the out-of-range rule applies.
REQ-029 f_step=0 (linear) or f_start=0 (log): the word never changes and the run continues until abort; no error is flagged.
REQ-030 abort in any non-IDLE state: go to IDLE next cycle; freq_word retains its value; done is not asserted.
REQ-031 abort and start in the same cycle in IDLE: abort wins; the start is dropped.
REQ-032 Total latency from STEP entry to the new freq_word: 1 cycle.

Reset
REQ-033 rst low asynchronously forces: state=IDLE, freq_word=RST_FREQ, freq_valid=0, busy=0, done=0, dwell counter=0, latched configuration=0.
REQ-034 Reset mid-sweep discards the run; after rst rises, the block waits for a new start.

Configuration
REQ-035 Macro FREQ_SWEEP_LOG_EN defined: mode 10 performs the log sweep in REQ-024.
REQ-036 Macro FREQ_SWEEP_LOG_EN undefined: the log datapath is absent, and mode 10 behaves as mode 01.

Verification
REQ-037 Reset release, no start -> freq_word=153722867281, busy=0, freq_valid=0.
REQ-038 mode=01, f_start=100, f_step=50, f_stop=200, dwell=2, repeat=0 -> words 100,150,200, each held 3 cycles, then done pulse, IDLE, freq_word=200.
REQ-039 Same as REQ-038 with repeat=1 -> sequence 100,150,200,100,...; done never pulses; abort -> IDLE, freq_word held.
REQ-040 mode=10, f_start=1, f_stop=1000, dwell=0 -> words 1,10,100,1000, then done (with FREQ_SWEEP_LOG_EN defined); without the macro -> linear behaviour.
REQ-041 mode=01, f_start=2^64-10, f_step=20, f_stop=2^64-1 -> carry detected, done pulses, freq_word=2^64-10.
REQ-042 mode=00, f_start=153722867280913000, then start pulsed again while busy -> word constant and the second start ignored; start and abort asserted together in IDLE -> remains IDLE.
